// File: rtl/bcd_ex3_seq_ctrl_if.sv
// Handshake bundle between a BCD producer, the sequencer and the Excess-3
// consumer.
//   in_valid/in_ready/bcd_in           : input word handshake
//   out_valid/out_ready                : result handshake
//   ex3_out/err/err_mask               : result payload
// slave  = the sequencer, master = producer/consumer side.
interface bcd_ex3_seq_ctrl_if #(
  parameter int unsigned DIGITS = 4
);
  localparam int unsigned W = 4 * DIGITS;

  logic              in_valid;
  logic              in_ready;
  logic [W-1:0]      bcd_in;
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      ex3_out;
  logic              err;
  logic [DIGITS-1:0] err_mask;

  modport master (
    output in_valid, bcd_in, out_ready,
    input  in_ready, out_valid, ex3_out, err, err_mask
  );

  modport slave (
    input  in_valid, bcd_in, out_ready,
    output in_ready, out_valid, ex3_out, err, err_mask
  );
endinterface

// File: rtl/bcd_ex3_seq_ctrl.sv
// Time-shares one external 4-bit BCD->Excess-3 converter across a packed
// DIGITS-digit BCD word, LSD first, one digit per cycle.
//   clk, rst      : clock, asynchronous active-high reset
//   bus (slave)   : in/out valid-ready handshakes and packed result
//   conv_b        : digit presented to the shared converter (0 when not converting)
//   conv_ex3      : converter result for conv_b, same cycle
module bcd_ex3_seq_ctrl #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  bcd_ex3_seq_ctrl_if.slave   bus,
  output logic [3:0]          conv_b,
  input  logic [3:0]          conv_ex3
);
  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q;
  logic [W-1:0]      cap_q;
  logic [W-1:0]      work_q;
  logic [DIGITS-1:0] wmask_q;
  logic [W-1:0]      ex3_q;
  logic [DIGITS-1:0] mask_q;
  logic              err_q;

  logic [3:0]        cur_digit;
  logic              cur_bad;
  logic              last;
  logic [W-1:0]      work_nxt;
  logic [DIGITS-1:0] wmask_nxt;

  // Digit selection and merge of the current converter result into the
  // working copy; invalid digits are forced to F and flagged.
  always_comb begin
    cur_digit = 4'h0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (CW'(i) == cnt_q) cur_digit = cap_q[4*i +: 4];
    end
    cur_bad   = (cur_digit > 4'd9);
    last      = (cnt_q == CW'(DIGITS - 1));
    work_nxt  = work_q;
    wmask_nxt = wmask_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (CW'(i) == cnt_q) begin
        work_nxt[4*i +: 4] = cur_bad ? 4'hF : conv_ex3;
        wmask_nxt[i]       = cur_bad;
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_valid)  state_d = CONV;
      CONV:    if (last)          state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: capture, per-digit accumulation, publish on the final digit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      cap_q   <= '0;
      work_q  <= '0;
      wmask_q <= '0;
      ex3_q   <= '0;
      mask_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            cap_q   <= bus.bcd_in;
            cnt_q   <= '0;
            work_q  <= '0;
            wmask_q <= '0;
            ex3_q   <= '0;
            mask_q  <= '0;
            err_q   <= 1'b0;
          end
        end
        CONV: begin
          work_q  <= work_nxt;
          wmask_q <= wmask_nxt;
          // Counter holds at the last digit instead of wrapping.
          if (!last) cnt_q <= cnt_q + CW'(1);
          if (last) begin
            ex3_q  <= work_nxt;
            mask_q <= wmask_nxt;
            err_q  <= |wmask_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  // Handshake flags are state decodes; conv_b is idle-zero outside CONV.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.ex3_out   = ex3_q;
  assign bus.err_mask  = mask_q;
  assign bus.err       = err_q;
  assign conv_b        = (state_q == CONV) ? cur_digit : 4'h0;

endmodule

// File: tb/tb_bcd_ex3_seq_ctrl.sv
// Bench for bcd_ex3_seq_ctrl: a DIGITS=4 instance driven from a vector table
// plus hand sequences (timing, back-to-back, backpressure, reset abort), and
// a DIGITS=1 instance for the single-digit case.
module tb_bcd_ex3_seq_ctrl;
  localparam int unsigned DIGITS = 4;

  logic clk;
  logic rst;
  logic [3:0] conv_b, conv_ex3;
  logic [3:0] conv_b1, conv_ex3_1;

  bcd_ex3_seq_ctrl_if #(.DIGITS(DIGITS)) bus ();
  bcd_ex3_seq_ctrl_if #(.DIGITS(1))      bus1 ();

  bcd_ex3_seq_ctrl #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .conv_b(conv_b), .conv_ex3(conv_ex3)
  );

  bcd_ex3_seq_ctrl #(.DIGITS(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave), .conv_b(conv_b1), .conv_ex3(conv_ex3_1)
  );

  // External converter; returns junk (5) for non-BCD digits, which must be ignored.
  assign conv_ex3   = (conv_b  <= 4'd9) ? conv_b  + 4'd3 : 4'h5;
  assign conv_ex3_1 = (conv_b1 <= 4'd9) ? conv_b1 + 4'd3 : 4'h5;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [15:0] ex3;
    logic [3:0]  mask;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [15:0] bcd;
    logic [15:0] ex3;
    logic [3:0]  mask;
  } vec_t;

  // Edge bookkeeping: cyc counts rising edges seen so far.
  int cyc = 0;
  int acc_edge = 0, acc_prev = 0, hs_edge = 0;
  logic ov_prev = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: handshake bookkeeping, latency and scoreboard compare.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.in_valid && bus.in_ready) begin
        acc_prev = acc_edge;
        acc_edge = cyc + 1;
      end
      // out_valid is high after the (DIGITS+1)-th edge counting the accepting edge.
      if (bus.out_valid && !ov_prev)
        check("latency_edges", 32'(cyc - acc_edge + 1), 32'(DIGITS + 1));
      if (bus.out_valid && bus.out_ready) begin
        hs_edge = cyc + 1;
        if (sb.size() == 0) begin
          check("unexpected_output", 32'(bus.ex3_out), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sb_ex3_out",  32'(bus.ex3_out),  32'(e.ex3));
          check("sb_err_mask", 32'(bus.err_mask), 32'(e.mask));
          check("sb_err",      32'(bus.err),      32'(|e.mask));
        end
      end
    end
    ov_prev = bus.out_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a word and wait (bounded) until it is accepted; returns just after
  // the accepting edge.
  task automatic send(input logic [15:0] bcd, input bit push,
                      input logic [15:0] ex3, input logic [3:0] mask, input bit hold);
    bit done;
    exp_t e;
    done = 1'b0;
    if (push) begin
      e.ex3 = ex3;
      e.mask = mask;
      sb.push_back(e);
    end
    bus.in_valid = 1'b1;
    bus.bcd_in   = bcd;
    for (int n = 0; n < 40 && !done; n++) begin
      if (bus.in_ready) done = 1'b1;
      tick();
    end
    if (!done) check("accept_timeout", 32'd0, 32'd1);
    if (!hold) bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && sb.size() != 0; n++) tick();
    check("drain_empty", 32'(sb.size()), 32'd0);
    tick();
  endtask

  vec_t vt[8];
  logic [3:0] seq1 [4];

  initial begin
    vt[0] = '{bcd: 16'h1259, ex3: 16'h458C, mask: 4'b0000};
    vt[1] = '{bcd: 16'h0000, ex3: 16'h3333, mask: 4'b0000};
    vt[2] = '{bcd: 16'h9999, ex3: 16'hCCCC, mask: 4'b0000};
    vt[3] = '{bcd: 16'h9C57, ex3: 16'hCF8A, mask: 4'b0100};
    vt[4] = '{bcd: 16'h0481, ex3: 16'h37B4, mask: 4'b0000};
    vt[5] = '{bcd: 16'hABCD, ex3: 16'hFFFF, mask: 4'b1111};
    vt[6] = '{bcd: 16'h0F30, ex3: 16'h3F63, mask: 4'b0100};
    vt[7] = '{bcd: 16'h8765, ex3: 16'hBA98, mask: 4'b0000};
    seq1[0] = 4'h9; seq1[1] = 4'h5; seq1[2] = 4'h2; seq1[3] = 4'h1;

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.bcd_in = '0; bus.out_ready = 1'b1;
    bus1.in_valid = 1'b0; bus1.bcd_in = '0; bus1.out_ready = 1'b0;

    // Reset state
    #3;
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_ex3_out",   32'(bus.ex3_out),   32'd0);
    check("rst_err_mask",  32'(bus.err_mask),  32'd0);
    check("rst_err",       32'(bus.err),       32'd0);
    check("rst_conv_b",    32'(conv_b),        32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    tick();

    // Digit sequence LSD first, valid timing, in_ready return
    check("t1_in_ready", 32'(bus.in_ready), 32'd1);
    send(16'h1259, 1'b1, 16'h458C, 4'b0000, 1'b0);
    for (int k = 0; k < 4; k++) begin
      check("t1_conv_b", 32'(conv_b), 32'(seq1[k]));
      check("t1_out_valid_low", 32'(bus.out_valid), 32'd0);
      tick();
    end
    check("t1_out_valid_high", 32'(bus.out_valid), 32'd1);
    check("t1_ex3_out", 32'(bus.ex3_out), 32'h458C);
    tick();
    check("t1_in_ready_back", 32'(bus.in_ready), 32'd1);
    drain();

    // Vector table
    for (int i = 0; i < 8; i++) begin
      send(vt[i].bcd, 1'b1, vt[i].ex3, vt[i].mask, 1'b0);
      drain();
    end

    // Back-to-back with in_valid held; bcd_in changes mid-conversion
    send(16'h0000, 1'b1, 16'h3333, 4'b0000, 1'b1);
    send(16'h9999, 1'b1, 16'hCCCC, 4'b0000, 1'b0);
    check("t2_accept_spacing", 32'(acc_edge - acc_prev), 32'(DIGITS + 2));
    check("t2_accept_after_hs", 32'(acc_edge - hs_edge), 32'd1);
    drain();

    // Backpressure hold; new word offered during hold is ignored
    bus.out_ready = 1'b0;
    send(16'h0481, 1'b1, 16'h37B4, 4'b0000, 1'b0);
    for (int n = 0; n < 20 && !bus.out_valid; n++) tick();
    bus.in_valid = 1'b1;
    bus.bcd_in   = 16'h7777;
    for (int k = 0; k < 3; k++) begin
      check("t4_hold_out_valid", 32'(bus.out_valid), 32'd1);
      check("t4_hold_in_ready",  32'(bus.in_ready),  32'd0);
      check("t4_hold_ex3_out",   32'(bus.ex3_out),   32'h37B4);
      check("t4_hold_err_mask",  32'(bus.err_mask),  32'd0);
      tick();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check("t4_release_in_ready",  32'(bus.in_ready),  32'd1);
    check("t4_release_out_valid", 32'(bus.out_valid), 32'd0);
    drain();

    // Asynchronous reset mid-conversion discards the word
    send(16'h1234, 1'b0, 16'h0000, 4'b0000, 1'b0);
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("t5_out_valid", 32'(bus.out_valid), 32'd0);
    check("t5_in_ready",  32'(bus.in_ready),  32'd1);
    check("t5_ex3_out",   32'(bus.ex3_out),   32'd0);
    check("t5_conv_b",    32'(conv_b),        32'd0);
    check("t5_err_mask",  32'(bus.err_mask),  32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick();
    send(16'h5678, 1'b1, 16'h89AB, 4'b0000, 1'b0);
    drain();

    // Single-digit instance
    bus1.in_valid = 1'b1;
    bus1.bcd_in   = 4'hA;
    check("d1_in_ready", 32'(bus1.in_ready), 32'd1);
    tick();
    bus1.in_valid = 1'b0;
    check("d1_conv_b", 32'(conv_b1), 32'hA);
    check("d1_out_valid_low", 32'(bus1.out_valid), 32'd0);
    tick();
    check("d1_out_valid", 32'(bus1.out_valid), 32'd1);
    check("d1_ex3_out",   32'(bus1.ex3_out),   32'hF);
    check("d1_err_mask",  32'(bus1.err_mask),  32'd1);
    check("d1_err",       32'(bus1.err),       32'd1);
    bus1.out_ready = 1'b1;
    tick();
    check("d1_in_ready_back", 32'(bus1.in_ready), 32'd1);
    bus1.in_valid = 1'b1;
    bus1.bcd_in   = 4'h0;
    tick();
    bus1.in_valid = 1'b0;
    tick();
    check("d1b_out_valid", 32'(bus1.out_valid), 32'd1);
    check("d1b_ex3_out",   32'(bus1.ex3_out),   32'h3);
    check("d1b_err",       32'(bus1.err),       32'd0);
    check("d1b_err_mask",  32'(bus1.err_mask),  32'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bcd_ex3_seq_ctrl.md
Name: bcd_ex3_seq_ctrl

Overview:
Sequencer that time-shares one 4-bit combinational BCD-to-Excess-3 converter across a packed multi-digit BCD word. It accepts a word over a valid/ready handshake and feeds the digits to the external converter one per cycle, least significant digit first. It then reassembles the packed Excess-3 result, flags non-BCD digits, and holds the result on an output valid/ready handshake. It sits between a BCD producer and a downstream consumer; the converter is instantiated beside it and wired through the conv_* ports.

Parameters:
DIGITS, 4, number of BCD digits per word (1..8); data width = 4*DIGITS.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  producer has a word on bcd_in.
in_ready  output  1  controller can accept a word.
bcd_in  input  4*DIGITS  packed BCD word; digit i = bits [4i+3:4i].
conv_b  output  4  digit currently driven to the shared converter.
conv_ex3  input  4  converter result for conv_b, combinational, same cycle.
out_valid  output  1  ex3_out/err/err_mask are valid.
out_ready  input  1  consumer accepts the result.
ex3_out  output  4*DIGITS  packed Excess-3 result.
err  output  1  OR of err_mask.
err_mask  output  DIGITS  bit i set if input digit i > 9.

Behaviour:
- Reset (async, rst=1): state IDLE, digit counter 0, capture register 0, ex3_out 0, err_mask 0, err 0, out_valid 0, conv_b 0, in_ready 1 (decoded from IDLE). Reset mid-operation aborts the word and discards partial results. No output is produced for an aborted word.
- States: IDLE, CONV, DONE. in_ready = (state==IDLE). out_valid = (state==DONE).
- IDLE:
  - On the edge with in_valid & in_ready: capture bcd_in, clear the result register and err_mask, set counter=0, go to CONV.
  - conv_b = 0 in this state.
- CONV:
  - conv_b = captured digit[counter].
  - Each edge: if digit[counter] <= 9, result digit[counter] = conv_ex3.
  - Otherwise, result digit[counter] = 4'hF and err_mask[counter] = 1. conv_ex3 is ignored for invalid digits.
  - Counter increments each edge. After the edge that processes digit DIGITS-1, go to DONE.
  - Exactly DIGITS cycles are spent in CONV.
- DONE:
  - ex3_out, err_mask and err are stable and held while out_valid=1 and out_ready=0.
  - On the edge with out_ready=1, go to IDLE.
  - conv_b = 0.
  - in_valid is not accepted in DONE. After a completing handshake there is one IDLE cycle before the next capture, so the maximum rate is one word per DIGITS+2 cycles.
- Latency: out_valid rises DIGITS+1 edges after the accepting edge (5 for DIGITS=4).
- ex3_out, err_mask and err are registered and change only on the final CONV edge and on the capture edge (where they are cleared). No output glitches from conv_ex3 reach ex3_out.
- in_valid or bcd_in changing while not in IDLE has no effect.
- Counter width is clog2(DIGITS), minimum 1 bit. The counter never wraps inside CONV and is reset to 0 on capture.
- DIGITS=1: CONV lasts one cycle; behaviour otherwise identical.

Test Plan:
1. DIGITS=4, in_valid with bcd_in=16'h1259, out_ready=1 -> conv_b sequence 9,5,2,1 on consecutive cycles; out_valid high 5 edges after accept; ex3_out=16'h458C, err=0, err_mask=4'b0000; in_ready returns to 1 one cycle later.
2. bcd_in=16'h0000, then 16'h9999 back-to-back (in_valid held) -> ex3_out=16'h3333, then 16'hCCCC; second accept occurs exactly one cycle after the first out handshake (DIGITS+2 cycle spacing).
3. bcd_in=16'h9C57 -> ex3_out=16'hCF8A, err_mask=4'b0100, err=1.
4. Backpressure: bcd_in=16'h0481, out_ready=0 for 3 cycles after out_valid rises -> out_valid, ex3_out=16'h37B4 and in_ready=0 held unchanged; a new in_valid with bcd_in=16'h7777 during the hold is ignored. Release out_ready -> IDLE next cycle.
5. Reset mid-op: accept 16'h1234, assert rst asynchronously (between edges) after 2 CONV cycles -> immediately out_valid=0, in_ready=1, ex3_out=0, conv_b=0. After release, 16'h5678 converts to 16'h89AB with no residue from the aborted word.
6. DIGITS=1 build: bcd_in=4'hA -> out_valid 2 edges after accept, ex3_out=4'hF, err_mask=1'b1; bcd_in=4'h0 -> ex3_out=4'h3, err=0.
